// File: rtl/vector_lane_alu.sv
// Serial lane-wise vector ALU execute stage: one LANE_W lane per clock, result
// handed to the vector register write port through a valid/ready handshake.
module vector_lane_alu #(
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned NUM_LANES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    op,
    input  logic [LANE_W*NUM_LANES-1:0]   vA,
    input  logic [LANE_W*NUM_LANES-1:0]   vB,
    input  logic [LANE_W-1:0]             eA,
    input  logic [2:0]                    dir_esc_in,
    input  logic                          signal_esc_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANE_W*NUM_LANES-1:0]   result,
    output logic [2:0]                    dir_esc_out,
    output logic                          signal_esc_out,
    output logic                          busy
);

    localparam int unsigned VEC_W = LANE_W * NUM_LANES;
    localparam int unsigned CNT_W = $clog2(NUM_LANES);
    localparam int unsigned SH_W  = $clog2(LANE_W);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [VEC_W-1:0]   va_q;
    logic [VEC_W-1:0]   vb_q;
    logic [LANE_W-1:0]  ea_q;
    logic [2:0]         dir_q;
    logic               en_q;
    logic               out_valid_q;
    logic [VEC_W-1:0]   result_q;
    logic [VEC_W-1:0]   result_d;
    logic [LANE_W-1:0]  lane_a;
    logic [LANE_W-1:0]  lane_b;
    logic [LANE_W-1:0]  lane_res;

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                lane_a = va_q[i*LANE_W +: LANE_W];
                lane_b = vb_q[i*LANE_W +: LANE_W];
            end
        end
    end

    // All ops are evaluated at lane width, so wrap-around is implicit.
    always_comb begin
        lane_res = '0;
        case (op_q)
            3'b000:  lane_res = lane_a + lane_b;
            3'b001:  lane_res = lane_a - lane_b;
            3'b010:  lane_res = lane_a ^ lane_b;
            3'b011:  lane_res = lane_a & lane_b;
            3'b100:  lane_res = lane_a | lane_b;
            3'b101:  lane_res = lane_a + ea_q;
            3'b110:  lane_res = lane_a * ea_q;
            default: lane_res = lane_a << ea_q[SH_W-1:0];
        endcase
    end

    always_comb begin
        result_d = result_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                result_d[i*LANE_W +: LANE_W] = lane_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            va_q        <= '0;
            vb_q        <= '0;
            ea_q        <= '0;
            dir_q       <= '0;
            en_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        va_q     <= vA;
                        vb_q     <= vB;
                        ea_q     <= eA;
                        dir_q    <= dir_esc_in;
                        en_q     <= signal_esc_in;
                        cnt_q    <= '0;
                        result_q <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    result_q <= result_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NUM_LANES - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign out_valid      = out_valid_q;
    assign result         = result_q;
    assign dir_esc_out    = dir_q;
    assign signal_esc_out = out_valid_q & out_ready & en_q;

endmodule

// File: doc/vector_lane_alu.md
Name: vector_lane_alu

Overview:
- Execute stage directly downstream of the register-read (decode) stage.
- Consumes the two 64-bit vector operands and the 8-bit scalar operand read from the vector and scalar register banks.
- Performs a lane-wise operation serially, one 8-bit lane per clock, over 8 lanes.
- Hands the 64-bit result plus the write-back address and write-enable to the vector register bank write port via a valid/ready handshake.

Parameters:
- LANE_W, 8, bits per lane; also the scalar operand width.
- NUM_LANES, 8, lanes per vector. Vector width = LANE_W*NUM_LANES = 64.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  block can accept a new operation.
- op  input  3  operation select.
- vA  input  64  vector operand A.
- vB  input  64  vector operand B.
- eA  input  8  scalar operand.
- dir_esc_in  input  3  destination vector register.
- signal_esc_in  input  1  write-back requested.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- result  output  64  lane-wise result.
- dir_esc_out  output  3  latched destination register.
- signal_esc_out  output  1  write strobe: out_valid & out_ready & latched signal_esc_in.
- busy  output  1  state != IDLE.

Behaviour:
- Lane i = bits [8i+7:8i]. All arithmetic is modulo 2^8 per lane, with no carry between lanes.
- op encoding, per lane:
  - 000 A+B
  - 001 A-B
  - 010 A^B
  - 011 A&B
  - 100 A|B
  - 101 A+eA
  - 110 low 8 bits of A*eA
  - 111 A<<eA[2:0], zero fill
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. When in_valid=1 at a rising edge, latch op, vA, vB, eA, dir_esc_in and signal_esc_in. Clear lane counter to 0, clear the result register, go to BUSY.
  - BUSY: each edge writes lane[cnt] of result with the op output for lane cnt, then cnt++. At the edge where cnt==NUM_LANES-1, go to DONE.
  - DONE: out_valid=1. result, dir_esc_out and signal_esc_out's latched enable are stable. When out_ready=1 at an edge, go to IDLE.
- Latency: handshake at edge k, then out_valid high after edge k+NUM_LANES (8 clocks).
- Throughput: one op per NUM_LANES+2 clocks when out_ready is held high (accept edge, 8 BUSY edges, DONE edge).
- in_ready=0 in BUSY and DONE. in_valid is ignored there, and operands are not re-sampled.
- Input changes during BUSY have no effect; only latched copies are used.
- out_ready is ignored outside DONE.
- If signal_esc_in=0 was latched, signal_esc_out stays 0. The result is still presented and still needs the handshake.
- Reset values (async, immediate):
  - state=IDLE, cnt=0
  - result=0, dir_esc_out=0, latched enable=0
  - out_valid=0, signal_esc_out=0, busy=0
  - in_ready=1 (no accept occurs while rst is high)
- Reset mid-operation aborts the op with no partial output: out_valid and signal_esc_out never pulse for it.
- During BUSY, lanes not yet written read 0 on result. Consumers must use result only when out_valid=1.
- out_valid, result and dir_esc_out are registered. signal_esc_out is combinational from out_valid, out_ready and the latched enable.

Test Plan:
- Lane-wise add wrap:
  - Stimulus: op=000, vA=0xFF01_0203_0405_0607, vB=0x0101_0101_0101_0101, signal_esc_in=1, dir_esc_in=5, out_ready=1.
  - Required: out_valid rises exactly 8 clocks after accept; result=0x0002_0304_0506_0708; dir_esc_out=5; signal_esc_out pulses for 1 cycle; back in IDLE the next cycle.
- Scalar ops:
  - op=110, vA=0x1020_3040_5060_7080, eA=0x03 -> result=0x3060_90C0_F020_5080.
  - op=111, eA=0x09 (shift 1), vA=0x8181_8181_8181_8181 -> result=0x0202_0202_0202_0202.
- Subtract underflow and logic ops:
  - op=001, vA=0x00..00, vB=0x01..01 -> result=0xFFFF_FFFF_FFFF_FFFF.
  - op=010 with vA=vB -> result=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, result and dir_esc_out stay stable; in_ready=0; a new in_valid is ignored.
  - Release out_ready -> exactly one signal_esc_out pulse.
- Reset mid-op:
  - Assert rst at lane 4 of a BUSY op -> result=0, out_valid=0 immediately, busy=0, and no signal_esc_out pulse.
  - After rst deasserts, a new op completes correctly.
- No-write op:
  - signal_esc_in=0, op=100 -> result correct; out_valid handshake occurs; signal_esc_out stays 0 throughout.
